// File: rtl/mux_select_arbiter.sv
// mux_select_arbiter: round-robin owner selection for a shared N-input mux with a bounded hold time
module mux_select_arbiter #(
    parameter int N        = 4,
    parameter int SW       = $clog2(N),
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] sel,
    output logic          busy,
    output logic          expired
);
    localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [SW-1:0]  sel_q, sel_d;
    logic [SW-1:0]  last_q, last_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           exp_q, exp_d;
    logic           found;
    logic [SW-1:0]  win;
    logic [SW-1:0]  idx;

    // Search for the first requester after the previous owner, wrapping modulo N
    always_comb begin
        found = 1'b0;
        win   = last_q;
        idx   = last_q;
        for (int k = 1; k <= N; k++) begin
            idx = SW'((int'(last_q) + k) % N);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Next-state and output decode; sel_q doubles as the owner index while granting
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        exp_d   = 1'b0;
        if (state_q == IDLE) begin
            if (found) begin
                state_d = GRANT;
                grant_d = N'(1) << win;
                sel_d   = win;
                last_d  = win;
                busy_d  = 1'b1;
                cnt_d   = CW'(1);
            end
        end else if (!req[sel_q]) begin
            state_d = IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
        end else if (MAX_HOLD != 0 && cnt_q == CW'(MAX_HOLD)) begin
            state_d = IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
            exp_d   = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // State registers; reset clears outputs immediately and gives requester 0 first priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            last_q  <= SW'(N - 1);
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            exp_q   <= exp_d;
        end
    end

    assign grant   = grant_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign expired = exp_q;
endmodule

// File: tb/tb_mux_select_arbiter.sv
// tb_mux_select_arbiter: directed and randomized checks of the arbiter against a tenure-level model
module tb_mux_select_arbiter;
    localparam int N = 4;
    localparam int SW = 2;
    localparam int MAX_HOLD = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  grant;
    logic [SW-1:0] sel;
    logic          busy;
    logic          expired;

    int checks = 0;
    int errors = 0;

    // Model: owner index (-1 idle), cycles held in this tenure, previous owner, last select, expiry pulse
    int m_owner, m_hold, m_last, m_sel, m_exp;

    mux_select_arbiter #(.N(N), .SW(SW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .reset(reset), .req(req),
        .grant(grant), .sel(sel), .busy(busy), .expired(expired)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] m_grant();
        return (m_owner < 0) ? '0 : N'(1 << m_owner);
    endfunction

    task automatic model_reset();
        m_owner = -1; m_hold = 0; m_last = N - 1; m_sel = 0; m_exp = 0;
    endtask

    // Advance one clock: apply the arbitration rules to the current req, then sample 1 time unit after the edge
    task automatic step();
        m_exp = 0;
        if (m_owner < 0) begin
            for (int k = 1; k <= N; k++)
                if (m_owner < 0 && req[(m_last + k) % N]) begin
                    m_owner = (m_last + k) % N;
                    m_hold = 1; m_last = m_owner; m_sel = m_owner;
                end
        end else if (!req[m_owner]) begin
            m_owner = -1;
        end else if (MAX_HOLD != 0 && m_hold == MAX_HOLD) begin
            m_owner = -1; m_exp = 1;
        end else begin
            m_hold++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic hard_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        req = 4'b0100;
        step(); step();
        reset = 1'b1;
        #1;
        checks++;
        if (grant !== 4'b0000 || sel !== 2'd0 || busy !== 1'b0 || expired !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: grant=%b sel=%0d busy=%b expired=%b, required 0000/0/0/0", grant, sel, busy, expired);
        end
        reset = 1'b0;
        model_reset();
        req = '0;
        step();
    endtask

    task automatic test_single();
        hard_reset();
        req = 4'b0001;
        step();
        checks++;
        if (grant !== 4'b0001 || sel !== 2'd0 || expired !== 1'b0) begin
            errors++;
            $display("FAIL single_first: grant=%b sel=%0d exp=%b, required 0001/0/0", grant, sel, expired);
        end
        step();
        checks++;
        if (grant !== 4'b0001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_hold: grant=%b busy=%b, required 0001/1", grant, busy);
        end
        req = 4'b0000;
        step();
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0 || expired !== 1'b0 || sel !== 2'd0) begin
            errors++;
            $display("FAIL single_release: grant=%b busy=%b exp=%b sel=%0d, required 0000/0/0/0", grant, busy, expired, sel);
        end
    endtask

    task automatic test_all_req();
        logic [N-1:0] exp_g [17] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
                                     4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
        hard_reset();
        req = 4'b1111;
        for (int i = 0; i < 17; i++) begin
            step();
            checks++;
            if (grant !== exp_g[i] || expired !== (i % 4 == 3) || (grant != 0 && sel !== SW'((i / 4) % N))) begin
                errors++;
                $display("FAIL all_req[%0d]: grant=%b exp=%b sel=%0d, required %b/%b/%0d", i, grant, expired, sel, exp_g[i], (i % 4 == 3), (i / 4) % N);
            end
        end
    endtask

    task automatic test_hog();
        hard_reset();
        req = 4'b0100;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (grant !== ((i % 4 == 3) ? 4'b0000 : 4'b0100) || expired !== (i % 4 == 3) || sel !== 2'd2) begin
                errors++;
                $display("FAIL hog[%0d]: grant=%b exp=%b sel=%0d", i, grant, expired, sel);
            end
        end
    endtask

    task automatic test_rr_order();
        hard_reset();
        req = 4'b0010;
        step();
        checks++;
        if (grant !== 4'b0010 || sel !== 2'd1) begin
            errors++;
            $display("FAIL rr_prev: grant=%b sel=%0d, required 0010/1", grant, sel);
        end
        req = 4'b0000;
        step();
        req = 4'b1011;
        step();
        checks++;
        if (grant !== 4'b1000 || sel !== 2'd3) begin
            errors++;
            $display("FAIL rr_order: grant=%b sel=%0d, required 1000/3", grant, sel);
        end
    endtask

    task automatic test_reset_mid();
        hard_reset();
        req = 4'b0100;
        step();
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: grant=%b busy=%b, required 0000/0", grant, busy);
        end
        #1;
        reset = 1'b0;
        model_reset();
        req = 4'b1111;
        step();
        checks++;
        if (grant !== 4'b0001 || sel !== 2'd0) begin
            errors++;
            $display("FAIL reset_regrant: grant=%b sel=%0d, required 0001/0", grant, sel);
        end
    endtask

    task automatic test_random();
        hard_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) req = N'($urandom);
            step();
            checks++;
            if (grant !== m_grant() || sel !== SW'(m_sel) || busy !== (m_owner >= 0) || expired !== m_exp[0]) begin
                errors++;
                $display("FAIL random[%0d]: req=%b grant=%b sel=%0d busy=%b exp=%b, required %b/%0d/%b/%0d",
                         i, req, grant, sel, busy, expired, m_grant(), m_sel, (m_owner >= 0), m_exp);
            end
            checks++;
            if (!$onehot0(grant) || busy !== |grant || (busy && grant[sel] !== 1'b1) || (busy && expired)) begin
                errors++;
                $display("FAIL invariants[%0d]: grant=%b sel=%0d busy=%b exp=%b", i, grant, sel, busy, expired);
            end
        end
    endtask

    initial begin
        model_reset();
        #3;
        reset = 1'b0;
        test_reset();
        test_single();
        test_all_req();
        test_hog();
        test_rr_order();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
